// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Walks a 3-input combinational cell through all eight input vectors in
// binary order. Each vector is held for HOLD_CYCLES clocks. The cell's
// response is captured into an 8-bit truth table and compared against
// EXP_TABLE as the sweep runs.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request a sweep (only looked at while idle)
//   a, b, c    - cell inputs, {a,b,c} is the current vector index
//   s1         - cell output, combinational response to a, b, c
//   busy       - high while vectors are being driven
//   done       - one-cycle pulse when a sweep completes
//   table_out  - captured s1 values, bit i belongs to vector i
//   err_count  - number of vectors whose s1 differed from EXP_TABLE
//   mismatch   - high when the last completed sweep had any error
module truth_table_sweeper #(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [7:0]  EXP_TABLE   = 8'hEA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  input  logic        s1,
  output logic        busy,
  output logic        done,
  output logic [7:0]  table_out,
  output logic [3:0]  err_count,
  output logic        mismatch
);

  // Refuse to build with a hold time the 4-bit hold counter cannot cover.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 16) begin : g_bad_hold
    $error("truth_table_sweeper: HOLD_CYCLES must be in 1..16");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [3:0]  hold_cnt;
  logic        vec_last;
  logic        vec_err;
  logic [3:0]  err_next;

  // The last hold cycle of a vector is when s1 is sampled. The error count
  // including the vector being sampled is formed here so the final verdict
  // can be registered on the same edge that enters DONE, making mismatch
  // valid in the DONE cycle itself.
  always_comb begin
    vec_last = (hold_cnt == HOLD_LAST);
    vec_err  = (s1 != EXP_TABLE[idx]);
    err_next = err_count + {3'b000, vec_err};
  end

  // Sweep controller. Every output is a flop; the cell inputs are updated
  // on the same edge that advances idx so {a,b,c} always tracks the vector
  // being held, and drop back to zero when the sweep ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      hold_cnt  <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= 8'h00;
      err_count <= 4'd0;
      mismatch  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            busy      <= 1'b1;
            idx       <= 3'd0;
            hold_cnt  <= 4'd0;
            {a, b, c} <= 3'b000;
            table_out <= 8'h00;
            err_count <= 4'd0;
            mismatch  <= 1'b0;
          end
        end

        DRIVE: begin
          if (vec_last) begin
            table_out[idx] <= s1;
            err_count      <= err_next;
            hold_cnt       <= 4'd0;
            if (idx == 3'd7) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              {a, b, c} <= 3'b000;
              mismatch  <= (err_next != 4'd0);
            end else begin
              idx       <= idx + 3'd1;
              {a, b, c} <= idx + 3'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Directed bench for truth_table_sweeper. Two instances share the clock:
// one with HOLD_CYCLES=4 for the main sweeps, one with HOLD_CYCLES=1 and
// start held high for the back-to-back boundary case. The cell under test
// is modelled as s1 = (a&b)|c, or tied low when 'fault' is set.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        fault;
  logic        a, b, c, s1;
  logic        busy, done, mismatch;
  logic [7:0]  table_out;
  logic [3:0]  err_count;

  logic        rst_n_h1;
  logic        start_h1;
  logic        a_h1, b_h1, c_h1, s1_h1;
  logic        busy_h1, done_h1, mismatch_h1;
  logic [7:0]  table_out_h1;
  logic [3:0]  err_count_h1;

  int check_count;
  int error_count;

  assign s1    = fault ? 1'b0 : ((a & b) | c);
  assign s1_h1 = (a_h1 & b_h1) | c_h1;

  truth_table_sweeper #(.HOLD_CYCLES(4), .EXP_TABLE(8'hEA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .s1(s1),
    .busy(busy), .done(done), .table_out(table_out),
    .err_count(err_count), .mismatch(mismatch)
  );

  truth_table_sweeper #(.HOLD_CYCLES(1), .EXP_TABLE(8'hEA)) dut_h1 (
    .clk(clk), .rst_n(rst_n_h1), .start(start_h1),
    .a(a_h1), .b(b_h1), .c(c_h1), .s1(s1_h1),
    .busy(busy_h1), .done(done_h1), .table_out(table_out_h1),
    .err_count(err_count_h1), .mismatch(mismatch_h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Pulses start so it is seen at exactly one rising edge (edge k), then
  // returns at the negedge inside cycle k+1.
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one HOLD_CYCLES=4 sweep and checks it cycle by cycle against the
  // expected timing: busy in cycles 1..32, {a,b,c}=(n-1)/4 while busy,
  // exactly one done pulse in cycle 33, and final results held afterwards.
  task automatic runSweep(input string name, input bit extra_starts,
                          input logic [7:0] exp_tab, input logic [3:0] exp_err,
                          input logic exp_mis);
    int done_seen;
    logic [2:0] exp_vec;
    done_seen = 0;
    applyStimulus();
    for (int n = 1; n <= 40; n++) begin
      exp_vec = (n >= 1 && n <= 32) ? 3'((n - 1) / 4) : 3'd0;
      checkOutput({name, "_busy"}, 32'(busy), 32'(n <= 32));
      checkOutput({name, "_done"}, 32'(done), 32'(n == 33));
      checkOutput({name, "_abc"}, 32'({a, b, c}), 32'(exp_vec));
      if (done) done_seen++;
      if (n == 33) begin
        checkOutput({name, "_table"}, 32'(table_out), 32'(exp_tab));
        checkOutput({name, "_err"}, 32'(err_count), 32'(exp_err));
        checkOutput({name, "_mismatch"}, 32'(mismatch), 32'(exp_mis));
      end
      if (extra_starts && (n == 5 || n == 20)) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput({name, "_done_count"}, 32'(done_seen), 32'd1);
    checkOutput({name, "_table_hold"}, 32'(table_out), 32'(exp_tab));
    checkOutput({name, "_err_hold"}, 32'(err_count), 32'(exp_err));
    checkOutput({name, "_mis_hold"}, 32'(mismatch), 32'(exp_mis));
  endtask

  initial begin
    int done_seen;
    check_count = 0;
    error_count = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    fault    = 1'b0;
    rst_n_h1 = 1'b0;
    start_h1 = 1'b0;

    // Reset held for three cycles, then released with start low.
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    rst_n_h1 = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_abc", 32'({a, b, c}), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_table", 32'(table_out), 32'h00);
    checkOutput("rst_err", 32'(err_count), 32'd0);
    checkOutput("rst_mismatch", 32'(mismatch), 32'd0);

    $display("[TB] good cell sweep");
    runSweep("good", 1'b0, 8'hEA, 4'd0, 1'b0);

    $display("[TB] faulty cell sweep");
    fault = 1'b1;
    runSweep("fault", 1'b0, 8'h00, 4'd5, 1'b1);
    fault = 1'b0;

    $display("[TB] start pulses while busy");
    runSweep("busy_start", 1'b1, 8'hEA, 4'd0, 1'b0);

    // Reset in cycle k+13 must clear everything immediately and suppress
    // the done pulse; a fresh start afterwards runs a full sweep.
    $display("[TB] reset mid-sweep");
    applyStimulus();
    repeat (12) @(negedge clk);
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_abc", 32'({a, b, c}), 32'd0);
    checkOutput("midrst_table", 32'(table_out), 32'h00);
    checkOutput("midrst_err", 32'(err_count), 32'd0);
    checkOutput("midrst_mismatch", 32'(mismatch), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checkOutput("midrst_no_activity", 32'(done_seen), 32'd0);
    runSweep("after_rst", 1'b0, 8'hEA, 4'd0, 1'b0);

    // HOLD_CYCLES=1 with start held high: sweeps repeat every 10 cycles,
    // busy in cycles 1..8 of each period and done in cycle 9.
    $display("[TB] HOLD_CYCLES=1 back-to-back");
    @(negedge clk);
    start_h1 = 1'b1;
    done_seen = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      checkOutput("h1_busy", 32'(busy_h1),
                  32'((n % 10) >= 1 && (n % 10) <= 8));
      checkOutput("h1_done", 32'(done_h1), 32'((n % 10) == 9));
      checkOutput("h1_abc", 32'({a_h1, b_h1, c_h1}),
                  ((n % 10) >= 1 && (n % 10) <= 8) ? 32'((n % 10) - 1) : 32'd0);
      if (done_h1) begin
        done_seen++;
        checkOutput("h1_table", 32'(table_out_h1), 32'hEA);
        checkOutput("h1_err", 32'(err_count_h1), 32'd0);
        checkOutput("h1_mismatch", 32'(mismatch_h1), 32'd0);
      end
    end
    checkOutput("h1_done_count", 32'(done_seen), 32'd4);
    start_h1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
